// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and helpers for the p2s round-robin scheduler
package p2s_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} sched_state_t;
  localparam int MAX_R = 32;
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction
  // First set bit of req at or above ptr, wrapping at r; falls back to ptr when req is empty.
  function automatic int unsigned rr_pick(input logic [MAX_R-1:0] req, input int unsigned ptr, input int unsigned r);
    int unsigned idx;
    rr_pick = ptr;
    for (int k = MAX_R - 1; k >= 0; k--) begin
      if (k < int'(r)) begin
        idx = ptr + k;
        if (idx >= r) idx -= r;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/p2s_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick from a request vector and a start pointer
//   req_i  request vector, ptr_i  search start index
//   gnt_o  chosen index, any_o  at least one request present
module rr_arbiter
  import p2s_pkg::*;
#(
  parameter int R = 4,
  localparam int GW = R > 1 ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] gnt_o,
  output logic          any_o
);
  assign any_o = |req_i;
  assign gnt_o = GW'(rr_pick(MAX_R'(req_i), 32'(ptr_i), R));
endmodule

// File: rtl/p2s_sched.sv
// p2s_sched: round-robin scheduler sharing one p2s serializer between R requesters
//   clk, rstn                       clock, async active-low reset
//   req_data/req_valid/req_ready    R requester words, valids, one-hot accept pulse
//   par_data/par_valid/par_ready    parallel port toward the p2s
//   ser_valid/ser_ready             p2s serial handshake, monitored to count beats
//   grant_id, busy                  current/last grant, high outside IDLE
module p2s_sched
  import p2s_pkg::*;
#(
  parameter int N = 4,
  parameter int R = 4,
  parameter bit SEND_HDR = 1'b1,
  localparam int GW = R > 1 ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [R*N-1:0] req_data,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  output logic [N-1:0]   par_data,
  output logic           par_valid,
  input  logic           par_ready,
  input  logic           ser_valid,
  input  logic           ser_ready,
  output logic [GW-1:0]  grant_id,
  output logic           busy
);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] FRAME_BEATS = CW'(SEND_HDR ? 2 * N : N);
  if ($clog2(R) > N || R > MAX_R || R < 1) begin : g_bad_cfg
    $error("p2s_sched: unsupported R=%0d for N=%0d", R, N);
  end
  sched_state_t state_q;
  logic [GW-1:0] ptr_q, grant_q, pick;
  logic [N-1:0] hold_q, par_data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [R-1:0] req_ready_q;
  logic par_valid_q, busy_q, any_req, par_fire;
  rr_arbiter #(.R(R)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(pick),
    .any_o(any_req)
  );
  // Beats are counted from HDR/PAY entry, so header bits emitted before DRAIN are included.
  assign cnt_d = cnt_q + CW'(ser_valid && ser_ready);
  assign par_fire = par_valid_q && par_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      hold_q      <= '0;
      par_data_q  <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      par_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: if (any_req) begin
          hold_q      <= req_data[int'(pick)*N +: N];
          grant_q     <= pick;
          req_ready_q <= R'(1) << pick;
          cnt_q       <= '0;
          busy_q      <= 1'b1;
          state_q     <= SEND_HDR ? HDR : PAY;
        end
        HDR: begin
          cnt_q       <= cnt_d;
          par_valid_q <= 1'b1;
          par_data_q  <= par_fire ? hold_q : N'(grant_q);
          if (par_fire) state_q <= PAY;
        end
        PAY: begin
          cnt_q       <= cnt_d;
          par_valid_q <= !par_fire;
          par_data_q  <= hold_q;
          if (par_fire) state_q <= DRAIN;
        end
        DRAIN: begin
          cnt_q <= cnt_d;
          if (cnt_d >= FRAME_BEATS) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= grant_q == GW'(R - 1) ? '0 : grant_q + 1'b1;
          end
        end
      endcase
    end
  end
  assign req_ready = req_ready_q;
  assign par_data  = par_data_q;
  assign par_valid = par_valid_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_p2s_sched.sv
// tb_p2s_sched: scoreboard bench for p2s_sched (header and payload-only variants) with a p2s serializer model
module tb_p2s_sched;
  localparam int N = 4;
  localparam int R = 4;
  typedef struct {
    int k;
    int i;
    logic [N-1:0] d;
    int beats;
  } vec_t;
  logic clk, rstn, pr_block;
  logic [1:0][R*N-1:0] rd;
  logic [1:0][R-1:0] rv, rv_prev, acked;
  logic [1:0] sr;
  wire [1:0][R-1:0] rr;
  wire [1:0][N-1:0] pd;
  wire [1:0] pv, pr, sv, sbit, busy;
  wire [1:0][1:0] gid;
  logic [N:0] pq[$], sq[$];
  logic [1:0][N-1:0] sacc;
  int nb[2], bc[2];
  int n_chk, n_fail;
  vec_t tbl[5];
  p2s_sched #(.N(N), .R(R), .SEND_HDR(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_data(rd[0]), .req_valid(rv[0]), .req_ready(rr[0]),
    .par_data(pd[0]), .par_valid(pv[0]), .par_ready(pr[0]), .ser_valid(sv[0]), .ser_ready(sr[0]),
    .grant_id(gid[0]), .busy(busy[0])
  );
  p2s_sched #(.N(N), .R(R), .SEND_HDR(1'b0)) dut_nohdr (
    .clk(clk), .rstn(rstn), .req_data(rd[1]), .req_valid(rv[1]), .req_ready(rr[1]),
    .par_data(pd[1]), .par_valid(pv[1]), .par_ready(pr[1]), .ser_valid(sv[1]), .ser_ready(sr[1]),
    .grant_id(gid[1]), .busy(busy[1])
  );
  // p2s serializer model: takes a word when empty, then shifts it out LSB first.
  for (genvar g = 0; g < 2; g++) begin : ser
    logic [N-1:0] sh;
    int left;
    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sh <= '0;
        left <= 0;
      end else if (left == 0) begin
        if (pv[g] && !pr_block) begin
          sh <= pd[g];
          left <= N;
        end
      end else if (sr[g]) begin
        sh <= sh >> 1;
        left <= left - 1;
      end
    end
    assign pr[g] = left == 0 && !pr_block;
    assign sv[g] = left != 0;
    assign sbit[g] = sh[0];
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name, input int act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected no transfer", name, act);
  endtask
  // Monitor samples 2 time units after the falling edge, once all bench drives have settled,
  // and predicts the handshakes that complete on the following rising edge.
  always @(negedge clk) begin
    #2;
    if (!rstn) begin
      nb[0] = 0;
      nb[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pv[k] && pr[k]) begin
          if (pq.size() == 0) fail_now("par_unexpected", int'(pd[k]));
          else chk("par_word", int'({1'(k), pd[k]}), int'(pq.pop_front()));
        end
        if (sv[k] && sr[k]) begin
          bc[k]++;
          sacc[k][nb[k]] = sbit[k];
          nb[k]++;
          if (nb[k] == N) begin
            nb[k] = 0;
            if (sq.size() == 0) fail_now("ser_unexpected", int'(sacc[k]));
            else chk("ser_word", int'({1'(k), sacc[k]}), int'(sq.pop_front()));
          end
        end
        for (int i = 0; i < R; i++)
          assert (!(rv_prev[k][i] && !rv[k][i] && !(acked[k][i] || rr[k][i])))
            else $error("requester %0d of dut %0d dropped req_valid before its req_ready", i, k);
      end
    end
    acked = rstn ? (acked | rr) & rv : '0;
    rv_prev = rv;
  end
  task automatic push_exp(input int k, input int i, input logic [N-1:0] d);
    if (k == 0) begin
      pq.push_back({1'b0, N'(i)});
      sq.push_back({1'b0, N'(i)});
    end
    pq.push_back({1'(k), d});
    sq.push_back({1'(k), d});
  endtask
  task automatic issue(input int k, input int i, input logic [N-1:0] d);
    rd[k][i*N +: N] = d;
    rv[k][i] = 1'b1;
    push_exp(k, i, d);
  endtask
  task automatic wait_ack(input int k, input int i, input bit lat);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (rr[k] == '0 && w < 50);
    chk("ack_onehot", int'(rr[k]), 1 << i);
    if (lat) chk("ack_latency", w, 1);
    rv[k][i] = 1'b0;
    chk("grant_id", int'(gid[k]), i);
    chk("busy_on_grant", int'(busy[k]), 1);
    @(negedge clk);
    chk("ack_pulse_width", int'(rr[k]), 0);
    if (lat) chk("par_valid_latency", int'(pv[k]), 1);
  endtask
  task automatic wait_idle(input int k, input int beats, input int b0);
    int w;
    w = 0;
    while (busy[k] && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("frame_done", int'(busy[k]), 0);
    chk("frame_beats", bc[k] - b0, beats);
    chk("par_queue_drained", pq.size(), 0);
    chk("ser_queue_drained", sq.size(), 0);
  endtask
  initial begin
    int b0, w;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0, w;
    n_chk = 0;
    n_fail = 0;
    bc[0] = 0;
    bc[1] = 0;
    rstn = 1'b0;
    rv = '0;
    rd = '0;
    sr = 2'b11;
    pr_block = 1'b0;
    tbl[0] = '{0, 2, 4'b1010, 8};
    tbl[1] = '{0, 0, 4'h5, 8};
    tbl[2] = '{0, 3, 4'hC, 8};
    tbl[3] = '{1, 1, 4'b0011, 4};
    tbl[4] = '{1, 0, 4'hE, 4};
    #1 chk("reset_outputs", int'({pv, pd, rr, gid, busy}), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      b0 = bc[tbl[t].k];
      issue(tbl[t].k, tbl[t].i, tbl[t].d);
      wait_ack(tbl[t].k, tbl[t].i, 1'b1);
      wait_idle(tbl[t].k, tbl[t].beats, b0);
      chk("grant_id_held", int'(gid[tbl[t].k]), tbl[t].i);
      @(negedge clk);
    end
    // All four at once with the pointer back at 0: grants 0,1,2,3 with whole frames in order.
    b0 = bc[0];
    for (int i = 0; i < R; i++) issue(0, i, N'(1 << i));
    for (int i = 0; i < R; i++) wait_ack(0, i, i == 0);
    wait_idle(0, 32, b0);
    @(negedge clk);
    // par_ready held low for 3 cycles while the header is offered.
    pr_block = 1'b1;
    b0 = bc[0];
    issue(0, 0, 4'h9);
    wait_ack(0, 0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      chk("hdr_stall_valid", int'(pv[0]), 1);
      chk("hdr_stall_data", int'(pd[0]), 0);
      if (j < 2) @(negedge clk);
    end
    pr_block = 1'b0;
    wait_idle(0, 8, b0);
    @(negedge clk);
    // ser_ready low for 2 cycles once DRAIN is entered.
    b0 = bc[0];
    issue(0, 1, 4'hF);
    wait_ack(0, 1, 1'b1);
    w = 0;
    while (!(pv[0] && pr[0] && pd[0] == 4'hF) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("payload_offered", int'(pd[0]), 4'hF);
    @(negedge clk);
    sr[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("drain_stall_busy", int'(busy[0]), 1);
      chk("drain_stall_par_valid", int'(pv[0]), 0);
    end
    sr[0] = 1'b1;
    wait_idle(0, 8, b0);
    @(negedge clk);
    // Reset while the payload word is being offered.
    issue(0, 2, 4'h5);
    wait_ack(0, 2, 1'b1);
    w = 0;
    while (!(pv[0] && pd[0] == 4'h5) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pay_reached", int'(pv[0]), 1);
    #3 rstn = 1'b0;
    #1 chk("midframe_reset_outputs", int'({pv, pd, rr, gid, busy}), 0);
    pq.delete();
    sq.delete();
    rv = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    b0 = bc[0];
    issue(0, 3, 4'b0110);
    wait_ack(0, 3, 1'b1);
    wait_idle(0, 8, b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
